wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Writeback arbiter between the execute/memory pipes and the 32x32 register file. It merges single-cycle ALU results and long-latency load/multiply (LSU) results onto the register file's single write port (RegWEn/AddrD/DataD). LSU results wait in a small FIFO. Younger ALU writes kill stale LSU writes to the same register. A pending-destination mask goes to decode for stall decisions.

## Interface
- DEPTH, 4, LSU result FIFO entries; a power of two, at least 2.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous to clk, active-low.
- alu_valid  input  1  ALU result present this cycle; never stalled.
- alu_rd  input  5  ALU destination register.
- alu_data  input  32  ALU result.
- lsu_valid  input  1  LSU offers a result.
- lsu_ready  output  1  FIFO can accept; a push occurs when lsu_valid && lsu_ready.
- lsu_rd  input  5  LSU destination register.
- lsu_data  input  32  LSU result.
- RegWEn  output  1  register-file write enable, registered.
- AddrD  output  5  register-file write address, registered.
- DataD  output  32  register-file write data, registered.
- pending_mask  output  32  bit r set while any live FIFO entry targets rd=r; bit 0 always 0.
- fifo_count  output  $clog2(DEPTH)+1  number of occupied FIFO entries, live or dead.

## Operation
- FIFO entry holds {live, rd, data}. Circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy count.
- Push: on lsu_valid && lsu_ready, append the entry. live = (lsu_rd != 0) and not killed by the rule below.
- lsu_ready = rst_n && (fifo_count < DEPTH). It depends on the registered count only.
  - When full, no push occurs in the same cycle as a pop; the freed slot is usable next cycle.
- ALU ownership: the ALU owns the write port in a cycle when alu_valid && alu_rd != 0.
  - The next RegWEn/AddrD/DataD are then 1/alu_rd/alu_data.
- Kill rule: when the ALU owns the port, every stored entry with rd == alu_rd has live cleared at this edge.
  - A concurrently pushed LSU entry with lsu_rd == alu_rd is also stored dead. LSU results are always older than a concurrent ALU result.
- Pop: at most one per cycle, at the head, when fifo_count != 0 and one of the following holds.
  - (a) Head is dead. It is discarded with no write, even if the ALU owns the port.
  - (b) Head is live and the ALU does not own the port. The next outputs are then 1/head.rd/head.data.
- A head made dead by a kill in the same cycle is still considered live for this cycle's pop decision. It cannot pop, because the ALU owns the port.
- No write this cycle: RegWEn <= 0. AddrD and DataD hold their previous values.
- Writes with rd=0 are never issued; ALU rd=0 results are dropped silently.
- pending_mask is combinational: the OR over occupied live entries of a one-hot decode of rd.
- Simultaneous push and pop: count is unchanged and both pointers advance.

## Timing
- Reset (rst_n low at a rising edge):
  - RegWEn=0, AddrD=0, DataD=0.
  - fifo_count=0, both pointers 0, all entries dead.
  - pending_mask=0, lsu_ready=0 while rst_n low.
- Reset mid-operation discards all buffered entries; no write is issued for them.
- ALU latency: result at edge N appears on RegWEn/AddrD/DataD after edge N. The register file captures it at edge N+1.
- LSU latency: a push at edge N is visible at the head after N.
  - The earliest pop decision is in cycle N+1, with outputs after edge N+1.
  - Minimum 2 edges from push to register-file write.
- pending_mask sets the cycle after the push edge. It clears the cycle after the pop or kill edge.
- Throughput: one register-file write per cycle; a dead entry drains in one cycle without a write.
- The ALU has absolute priority; LSU entries may starve under continuous ALU traffic. No timeout.

## Test plan
- Reset then idle:
  - rst_n=0 for 2 cycles -> RegWEn=0, AddrD=0, DataD=0, fifo_count=0, lsu_ready=0.
  - After release -> lsu_ready=1.
- ALU only: alu_valid=1, rd=5, data=32'h1234 at edge N -> RegWEn=1, AddrD=5, DataD=32'h1234 after N. An rd=0 ALU result -> RegWEn=0.
- Fill and drain:
  - With ALU idle, push DEPTH=4 LSU results (rd=1..4, data=32'hA1..A4) while a stall is held -> fifo_count=4, lsu_ready=0, pending_mask=32'h1E.
  - Then release -> writes to rd 1,2,3,4 in order on 4 consecutive cycles, count back to 0.
- Priority: LSU entry rd=7 queued while ALU writes rd=3 for 3 cycles -> three writes to rd 3, then rd 7 on the 4th cycle.
- Kill:
  - Queue LSU rd=9 data=32'hDEAD, then ALU writes rd=9 data=32'hBEEF -> AddrD=9/DataD=32'hBEEF.
  - The dead entry drains with RegWEn=0 and is never written; pending_mask bit 9 clears.
  - Same-cycle push lsu_rd=9 with ALU rd=9 -> stored dead.
- Full boundary and wrap: with count=4, assert lsu_valid during a pop -> no push that cycle (count=3), push next cycle. Run 10 push/pop pairs -> pointers wrap and data order is preserved.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and queued LSU results
// onto the register file's single write port. ALU results have absolute
// priority; younger ALU writes kill queued LSU writes to the same register.
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       alu_valid,
    input  logic [4:0]                 alu_rd,
    input  logic [31:0]                alu_data,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [4:0]                 lsu_rd,
    input  logic [31:0]                lsu_data,
    output logic                       RegWEn,
    output logic [4:0]                 AddrD,
    output logic [31:0]                DataD,
    output logic [31:0]                pending_mask,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // FIFO storage: live flags packed, rd and data as arrays
    logic [DEPTH-1:0] live_q, live_d;
    logic [4:0]       rd_q   [DEPTH];
    logic [31:0]      data_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic        reg_wen_q, reg_wen_d;
    logic [4:0]  addr_q, addr_d;
    logic [31:0] data_out_q, data_out_d;

    logic        alu_own;
    logic        push;
    logic        push_live;
    logic        head_live;
    logic        pop;
    logic [DEPTH-1:0] occupied;

    assign alu_own   = alu_valid && (alu_rd != 5'd0);
    assign lsu_ready = rst_n && (count_q < CNT_W'(DEPTH));
    assign push      = lsu_valid && lsu_ready;
    // An LSU result is always older than a concurrent ALU result to the same rd
    assign push_live = (lsu_rd != 5'd0) && !(alu_own && (lsu_rd == alu_rd));
    // Head liveness uses the pre-kill flag; a head killed this cycle still
    // cannot pop because the ALU owns the port.
    assign head_live = live_q[rd_ptr_q];
    assign pop       = (count_q != '0) && (!head_live || !alu_own);

    // Slot gi is occupied when its distance from the read pointer is below count
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
            logic [PTR_W-1:0] offset;
            assign offset       = PTR_W'(gi) - rd_ptr_q;
            assign occupied[gi] = {1'b0, offset} < count_q;
        end
    endgenerate

    // Next-state for FIFO flags, pointers, count and write-port outputs
    always_comb begin
        live_d     = live_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        reg_wen_d  = 1'b0;
        addr_d     = addr_q;
        data_out_d = data_out_q;

        // Kill stored entries targeting the register the ALU is writing now
        for (int i = 0; i < DEPTH; i++) begin
            if (alu_own && (rd_q[i] == alu_rd)) begin
                live_d[i] = 1'b0;
            end
        end

        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + 1'b1;
        end

        // Push slot can never be the pop slot: equal pointers imply empty or full
        if (push) begin
            live_d[wr_ptr_q] = push_live;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (alu_own) begin
            reg_wen_d  = 1'b1;
            addr_d     = alu_rd;
            data_out_d = alu_data;
        end else if (pop && head_live) begin
            reg_wen_d  = 1'b1;
            addr_d     = rd_q[rd_ptr_q];
            data_out_d = data_q[rd_ptr_q];
        end
    end

    // Control state and registered write port, with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            live_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            reg_wen_q  <= 1'b0;
            addr_q     <= 5'd0;
            data_out_q <= 32'd0;
        end else begin
            live_q     <= live_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            reg_wen_q  <= reg_wen_d;
            addr_q     <= addr_d;
            data_out_q <= data_out_d;
        end
    end

    // Payload storage; contents are meaningless unless the slot is occupied
    always_ff @(posedge clk) begin
        if (push) begin
            rd_q[wr_ptr_q]   <= lsu_rd;
            data_q[wr_ptr_q] <= lsu_data;
        end
    end

    // Pending-destination mask for decode stall logic
    always_comb begin
        pending_mask = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && occupied[i]) begin
                pending_mask = pending_mask | (32'd1 << rd_q[i]);
            end
        end
        pending_mask[0] = 1'b0;
    end

    assign RegWEn     = reg_wen_q;
    assign AddrD      = addr_q;
    assign DataD      = data_out_q;
    assign fifo_count = count_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (DEPTH=4).
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        RegWEn;
    logic [4:0]  AddrD;
    logic [31:0] DataD;
    logic [31:0] pending_mask;
    logic [2:0]  fifo_count;

    int total = 0;
    int bad   = 0;

    wb_arbiter #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_rd       (alu_rd),
        .alu_data     (alu_data),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .RegWEn       (RegWEn),
        .AddrD        (AddrD),
        .DataD        (DataD),
        .pending_mask (pending_mask),
        .fifo_count   (fifo_count)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle before sampling
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s mismatched", tag);
        end
    endtask

    task automatic check_wr(input string tag, input logic wen, input logic [4:0] rd, input logic [31:0] d);
        check({tag, ".wen"}, {31'd0, RegWEn}, {31'd0, wen});
        check({tag, ".addr"}, {27'd0, AddrD}, {27'd0, rd});
        check({tag, ".data"}, DataD, d);
    endtask

    initial begin
        rst_n = 1'b0; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0;

        // Reset then idle
        step(); step();
        check_wr("reset", 1'b0, 5'd0, 32'd0);
        check("reset.count", {29'd0, fifo_count}, 32'd0);
        check("reset.ready", {31'd0, lsu_ready}, 32'd0);
        check("reset.mask", pending_mask, 32'd0);
        rst_n = 1'b1;
        step();
        check("release.ready", {31'd0, lsu_ready}, 32'd1);
        check("release.wen", {31'd0, RegWEn}, 32'd0);

        // ALU only, then an rd=0 result that must be dropped
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        step();
        check_wr("alu5", 1'b1, 5'd5, 32'h1234);
        alu_rd = 5'd0; alu_data = 32'hFFFF;
        step();
        check_wr("alu0", 1'b0, 5'd5, 32'h1234);
        $display("txn alu rd5 then rd0");

        // Fill: ALU holds the port on rd 20, LSU pushes rd 1..4
        alu_rd = 5'd20; alu_data = 32'h2020;
        lsu_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            lsu_rd = 5'(i); lsu_data = 32'hA0 + 32'(i);
            step();
            check("fill.count", {29'd0, fifo_count}, 32'(i));
            $display("txn push rd=%0d count=%0d", i, fifo_count);
        end
        lsu_valid = 1'b0;
        check("fill.ready", {31'd0, lsu_ready}, 32'd0);
        check("fill.mask", pending_mask, 32'h1E);
        check_wr("fill.alu", 1'b1, 5'd20, 32'h2020);

        // Drain in order with ALU idle
        alu_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check_wr("drain", 1'b1, 5'(i), 32'hA0 + 32'(i));
            check("drain.count", {29'd0, fifo_count}, 32'(4 - i));
            $display("txn drain write rd=%0d data=%h", AddrD, DataD);
        end
        check("drain.mask", pending_mask, 32'd0);
        step();
        check("drain.idle", {31'd0, RegWEn}, 32'd0);

        // Priority: LSU rd 7 waits behind three ALU writes to rd 3
        lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h77;
        step();
        lsu_valid = 1'b0;
        check("prio.mask", pending_mask, 32'h80);
        alu_valid = 1'b1; alu_rd = 5'd3;
        for (int k = 0; k < 3; k++) begin
            alu_data = 32'h30 + 32'(k);
            step();
            check_wr("prio.alu", 1'b1, 5'd3, 32'h30 + 32'(k));
            $display("txn alu write rd=3 data=%h", DataD);
        end
        alu_valid = 1'b0;
        step();
        check_wr("prio.lsu", 1'b1, 5'd7, 32'h77);
        check("prio.count", {29'd0, fifo_count}, 32'd0);
        $display("txn lsu write rd=7 after alu");

        // Kill: queued rd 9 overwritten by a younger ALU write
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'hDEAD;
        step();
        lsu_valid = 1'b0;
        check("kill.mask_set", pending_mask, 32'h200);
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hBEEF;
        step();
        alu_valid = 1'b0;
        check_wr("kill.alu", 1'b1, 5'd9, 32'hBEEF);
        check("kill.mask_clr", pending_mask, 32'd0);
        check("kill.count", {29'd0, fifo_count}, 32'd1);
        step();
        check_wr("kill.drain", 1'b0, 5'd9, 32'hBEEF);
        check("kill.count0", {29'd0, fifo_count}, 32'd0);
        $display("txn kill rd=9 dead entry drained");

        // Same-cycle push and ALU write to rd 9: pushed entry stored dead
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h1111;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h2222;
        step();
        lsu_valid = 1'b0; alu_valid = 1'b0;
        check_wr("same.alu", 1'b1, 5'd9, 32'h2222);
        check("same.count", {29'd0, fifo_count}, 32'd1);
        check("same.mask", pending_mask, 32'd0);
        step();
        check_wr("same.drain", 1'b0, 5'd9, 32'h2222);
        check("same.count0", {29'd0, fifo_count}, 32'd0);
        $display("txn same-cycle kill rd=9");

        // Full boundary: fill rd 11..14 behind ALU rd 20
        alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h2020;
        lsu_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            lsu_rd = 5'(11 + i); lsu_data = 32'hB1 + 32'(i);
            step();
        end
        check("full.count", {29'd0, fifo_count}, 32'd4);
        alu_valid = 1'b0;
        lsu_rd = 5'd15; lsu_data = 32'hB5;
        step();
        check_wr("full.pop11", 1'b1, 5'd11, 32'hB1);
        check("full.nopush", {29'd0, fifo_count}, 32'd3);
        check("full.ready", {31'd0, lsu_ready}, 32'd1);
        step();
        lsu_valid = 1'b0;
        check_wr("full.pop12", 1'b1, 5'd12, 32'hB2);
        check("full.pushpop", {29'd0, fifo_count}, 32'd3);
        for (int i = 0; i < 3; i++) begin
            step();
            check_wr("full.drain", 1'b1, 5'(13 + i), 32'hB3 + 32'(i));
            $display("txn full drain rd=%0d", AddrD);
        end
        check("full.count0", {29'd0, fifo_count}, 32'd0);

        // Wrap: ten back-to-back pushes, each popped the following cycle
        lsu_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            lsu_rd = 5'((k % 30) + 1); lsu_data = 32'hC000_0000 + 32'(k);
            step();
            if (k > 0) begin
                check_wr("wrap", 1'b1, 5'(k), 32'hC000_0000 + 32'(k - 1));
                check("wrap.count", {29'd0, fifo_count}, 32'd1);
                $display("txn wrap pop rd=%0d data=%h", AddrD, DataD);
            end
        end
        lsu_valid = 1'b0;
        step();
        check_wr("wrap.last", 1'b1, 5'd10, 32'hC000_0009);
        check("wrap.count0", {29'd0, fifo_count}, 32'd0);

        // Reset mid-operation discards buffered entries with no write
        lsu_valid = 1'b1; lsu_rd = 5'd6; lsu_data = 32'h66;
        step();
        lsu_valid = 1'b0; rst_n = 1'b0;
        step();
        check_wr("midrst", 1'b0, 5'd0, 32'd0);
        check("midrst.count", {29'd0, fifo_count}, 32'd0);
        check("midrst.ready", {31'd0, lsu_ready}, 32'd0);
        rst_n = 1'b1;
        step();
        check("midrst.nowrite", {31'd0, RegWEn}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
